mu01_mem_arb: RTL

//   Shares the single-port 4K x 16 mu01 program/data memory between two requesters:

---
 rtl/mu01_pkg.sv | 22 ++
 rtl/mu01_rr_pick.sv | 15 +
 rtl/mu01_mem_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mu01_pkg.sv
// Shared mu01 definitions: memory geometry, arbiter owner encoding and core opcodes.
package mu01_pkg;

  localparam int unsigned MU01_AW = 12;
  localparam int unsigned MU01_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  // Core opcodes live in instruction bits [15:12].
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/mu01_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port not granted last.
module mu01_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) begin
      o_gnt = i_last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mu01_mem_arb.sv
// Arbitrates the single-port mu01 memory between the core (port 0) and the loader/debug
// port (port 1): round-robin with burst lock, starvation bound and fixed-latency read return.
module mu01_mem_arb
  import mu01_pkg::*;
#(
  parameter int unsigned AW       = MU01_AW,
  parameter int unsigned DW       = MU01_DW,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic          i_m0_lock,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_gnt,
  output logic          o_m0_rvalid,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic          i_m1_lock,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  output logic          o_m1_gnt,
  output logic          o_m1_rvalid,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  owner_e            r_owner;
  logic              r_last;
  logic [HW-1:0]     r_hold_cnt;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_port;

  logic [1:0] w_req;
  logic [1:0] w_rr_gnt;
  logic [1:0] w_gnt;
  logic       w_any;
  logic       w_sel;
  logic       w_sel_we;
  logic       w_sel_lock;
  logic       w_other_req;
  logic       w_starved;

  assign w_req = {i_m1_req, i_m0_req};

  mu01_rr_pick u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt)
  );

  assign w_starved = (r_hold_cnt == HOLD_MAX);

  // A locked owner keeps the memory unless the other port has waited MAX_HOLD grants.
  always_comb begin
    w_gnt = w_rr_gnt;
    if (r_owner == OWN_P0 && i_m0_req) begin
      w_gnt = (i_m1_req && w_starved) ? 2'b10 : 2'b01;
    end else if (r_owner == OWN_P1 && i_m1_req) begin
      w_gnt = (i_m0_req && w_starved) ? 2'b01 : 2'b10;
    end
    if (i_reset) begin
      w_gnt = 2'b00;
    end
  end

  assign w_any       = |w_gnt;
  assign w_sel       = w_gnt[1];
  assign w_sel_we    = w_sel ? i_m1_we   : i_m0_we;
  assign w_sel_lock  = w_sel ? i_m1_lock : i_m0_lock;
  assign w_other_req = w_sel ? i_m0_req  : i_m1_req;

  assign o_m0_gnt    = w_gnt[0];
  assign o_m1_gnt    = w_gnt[1];
  assign o_mem_en    = w_any;
  assign o_mem_we    = w_any & w_sel_we;
  assign o_mem_addr  = !w_any ? '0 : (w_sel ? i_m1_addr  : i_m0_addr);
  assign o_mem_wdata = !w_any ? '0 : (w_sel ? i_m1_wdata : i_m0_wdata);

  assign o_m0_rvalid = r_tag_vld[RD_LAT-1] & ~r_tag_port[RD_LAT-1];
  assign o_m1_rvalid = r_tag_vld[RD_LAT-1] &  r_tag_port[RD_LAT-1];
  assign o_m0_rdata  = i_mem_rdata;
  assign o_m1_rdata  = i_mem_rdata;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_owner    <= OWN_NONE;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
      r_tag_vld  <= '0;
      r_tag_port <= '0;
    end else begin
      r_tag_vld[0]  <= w_any & ~w_sel_we;
      r_tag_port[0] <= w_sel;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_port[i] <= r_tag_port[i-1];
      end
      if (w_any) begin
        r_last  <= w_sel;
        r_owner <= !w_sel_lock ? OWN_NONE : (w_sel ? OWN_P1 : OWN_P0);
        // Count only repeat grants that keep a waiting port out.
        if (w_sel == r_last && w_other_req) begin
          if (!w_starved) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end else begin
          r_hold_cnt <= '0;
        end
      end else begin
        r_owner    <= OWN_NONE;
        r_hold_cnt <= '0;
      end
    end
  end

endmodule
